// File: rtl/bus_host_arbiter.sv
// +------------------------------------------------------------------------+
// | bus_host_arbiter: round-robin share of one req/gnt/rvalid device port  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                host_req_i    [NrHosts],
  output logic                                host_gnt_o    [NrHosts],
  input  logic [AW-1:0]                       host_addr_i   [NrHosts],
  input  logic                                host_we_i     [NrHosts],
  input  logic [DW/8-1:0]                     host_be_i     [NrHosts],
  input  logic [DW-1:0]                       host_wdata_i  [NrHosts],
  output logic                                host_rvalid_o [NrHosts],
  output logic [DW-1:0]                       host_rdata_o  [NrHosts],
  output logic                                host_err_o    [NrHosts],
  output logic                                dev_req_o,
  input  logic                                dev_gnt_i,
  output logic [AW-1:0]                       dev_addr_o,
  output logic                                dev_we_o,
  output logic [DW/8-1:0]                     dev_be_o,
  output logic [DW-1:0]                       dev_wdata_o,
  input  logic                                dev_rvalid_i,
  input  logic [DW-1:0]                       dev_rdata_i,
  input  logic                                dev_err_i,
  output logic                                resp_unexpected_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

  localparam int IDW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CW  = $clog2(MaxOutstanding + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] sel;
  int             scan_idx;
  logic           full, grant, pop;

  logic [IDW-1:0] id_fifo [MaxOutstanding];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q;
  logic [IDW-1:0] head;
  logic           unexpected_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lock state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // A stalled request keeps its host until granted, or until that host withdraws
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (grant) begin
      state_d = ST_IDLE;
    end else if (dev_req_o) begin
      state_d   = ST_LOCKED;
      lock_id_d = sel;
    end else if (state_q == ST_LOCKED && !host_req_i[lock_id_q]) begin
      state_d = ST_IDLE;
    end
  end

  // Selection, device request and grant fan-out
  always_comb begin
    sel      = rr_ptr_q;
    scan_idx = 0;
    if (state_q == ST_LOCKED) begin
      sel = lock_id_q;
    end else begin
      for (int i = NrHosts - 1; i >= 0; i--) begin
        scan_idx = int'(rr_ptr_q) + i;
        if (scan_idx >= NrHosts) scan_idx = scan_idx - NrHosts;
        if (host_req_i[IDW'(scan_idx)]) sel = IDW'(scan_idx);
      end
    end
    // Full deliberately ignores a same-cycle pop to keep rvalid off the req path
    dev_req_o = host_req_i[sel] & ~full & ~rst_i;
    grant     = dev_req_o & dev_gnt_i;
    for (int i = 0; i < NrHosts; i++) begin
      host_gnt_o[i] = grant && (sel == IDW'(i));
    end
  end

  assign dev_addr_o  = host_addr_i[sel];
  assign dev_we_o    = host_we_i[sel];
  assign dev_be_o    = host_be_i[sel];
  assign dev_wdata_o = host_wdata_i[sel];

  assign full = (count_q == CW'(MaxOutstanding));
  assign pop  = dev_rvalid_i & (count_q != '0);
  assign head = id_fifo[rptr_q];

  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      host_rvalid_o[i] = pop && (head == IDW'(i));
      host_err_o[i]    = pop && (head == IDW'(i)) && dev_err_i;
      host_rdata_o[i]  = dev_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      unexpected_q <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr_q <= (sel == IDW'(NrHosts - 1)) ? '0 : sel + 1'b1;
        wptr_q   <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (grant && !pop) count_q <= count_q + CW'(1);
      else if (!grant && pop) count_q <= count_q - CW'(1);
      if (dev_rvalid_i && count_q == '0) unexpected_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) id_fifo[wptr_q] <= sel;
  end

  assign resp_unexpected_o = unexpected_q;
  assign outstanding_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_bus_host_arbiter: vector table plus response scoreboard             |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_bus_host_arbiter;

  localparam logic [31:0] A0  = 32'h0010_0010;
  localparam logic [31:0] A1  = 32'h0003_0000;
  localparam logic [31:0] WD0 = 32'h0000_1234;
  localparam logic [31:0] WD1 = 32'h5678_9ABC;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  x_gnt;
    logic        x_req;
    logic [31:0] x_addr;
    logic [1:0]  x_out;
    logic        x_unexp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        host_req    [2];
  logic        host_gnt    [2];
  logic [31:0] host_addr   [2];
  logic        host_we     [2];
  logic [3:0]  host_be     [2];
  logic [31:0] host_wdata  [2];
  logic        host_rvalid [2];
  logic [31:0] host_rdata  [2];
  logic        host_err    [2];
  logic        dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, resp_unexp;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dev_be;
  logic [1:0]  outstanding;

  int   checks = 0;
  int   errors = 0;
  int   sb [$];
  vec_t vecs [$];

  bus_host_arbiter #(.NrHosts(2), .AW(32), .DW(32), .MaxOutstanding(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
    .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
    .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .resp_unexpected_o(resp_unexp), .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic [1:0] rq,
                              input logic g, input logic v, input logic [31:0] rd,
                              input logic e, input logic [1:0] xg, input logic xr,
                              input logic [31:0] xa, input logic [1:0] xo, input logic xu);
    vec_t t;
    t.name = n; t.rst = r; t.req = rq; t.gnt = g; t.rv = v; t.rdata = rd; t.err = e;
    t.x_gnt = xg; t.x_req = xr; t.x_addr = xa; t.x_out = xo; t.x_unexp = xu;
    return t;
  endfunction

  // Drive on the falling edge, compare just before the next rising edge
  task automatic step(input vec_t v);
    int h;
    @(negedge clk);
    rst         = v.rst;
    host_req[0] = v.req[0];
    host_req[1] = v.req[1];
    dev_gnt     = v.gnt;
    dev_rvalid  = v.rv;
    dev_rdata   = v.rdata;
    dev_err     = v.err;
    #4;
    chk({v.name, ".gnt"}, {30'd0, host_gnt[1], host_gnt[0]}, {30'd0, v.x_gnt});
    chk({v.name, ".req"}, {31'd0, dev_req}, {31'd0, v.x_req});
    if (v.x_req) begin
      chk({v.name, ".addr"}, dev_addr, v.x_addr);
      chk({v.name, ".we"}, {31'd0, dev_we}, {31'd0, (v.x_addr == A1)});
      chk({v.name, ".wdata"}, dev_wdata, (v.x_addr == A1) ? WD1 : WD0);
    end
    chk({v.name, ".out"}, {30'd0, outstanding}, {30'd0, v.x_out});
    chk({v.name, ".unexp"}, {31'd0, resp_unexp}, {31'd0, v.x_unexp});
    if (v.rv && !v.rst && sb.size() > 0) begin
      h = sb.pop_front();
      chk({v.name, ".rv_host"}, {30'd0, host_rvalid[1], host_rvalid[0]}, 32'(1 << h));
      chk({v.name, ".rdata"}, host_rdata[h], v.rdata);
      chk({v.name, ".err"}, {30'd0, host_err[1], host_err[0]}, v.err ? 32'(1 << h) : 32'd0);
    end else begin
      chk({v.name, ".no_rv"}, {30'd0, host_rvalid[1], host_rvalid[0]}, 32'd0);
      chk({v.name, ".no_err"}, {30'd0, host_err[1], host_err[0]}, 32'd0);
    end
    if (v.rst) sb.delete();
    else begin
      if (v.x_gnt[0]) sb.push_back(0);
      if (v.x_gnt[1]) sb.push_back(1);
    end
  endtask

  initial begin
    rst = 1'b1;
    host_req[0] = 1'b0; host_req[1] = 1'b0;
    host_addr[0] = A0;  host_addr[1] = A1;
    host_we[0] = 1'b0;  host_we[1] = 1'b1;
    host_be[0] = 4'hF;  host_be[1] = 4'h3;
    host_wdata[0] = WD0; host_wdata[1] = WD1;
    dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;

    //          name      rst req gnt rv rdata          err xgnt  xreq xaddr xout xunexp
    vecs.push_back(mk("rst_hold", 1, 2'b11, 1, 1, 32'h0,        0, 2'b00, 0, A0, 0, 0));
    vecs.push_back(mk("rst_rel",  0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, A0, 0, 0));
    vecs.push_back(mk("rd_gnt",   0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, A0, 0, 0));
    vecs.push_back(mk("rd_rsp",   0, 2'b00, 1, 1, 32'hDEADBEEF, 0, 2'b00, 0, A0, 1, 0));
    vecs.push_back(mk("h1_gnt",   0, 2'b10, 1, 0, 32'h0,        0, 2'b10, 1, A1, 0, 0));
    vecs.push_back(mk("h1_rsp",   0, 2'b00, 0, 1, 32'h1111_1111, 0, 2'b00, 0, A0, 1, 0));
    for (int c = 0; c < 8; c++)
      vecs.push_back(mk($sformatf("rr%0d", c), 0, 2'b11, 1, (c > 0), 32'hA000_0000 + c, 0,
                        (c % 2 == 0) ? 2'b01 : 2'b10, 1, (c % 2 == 0) ? A0 : A1,
                        (c > 0) ? 2'd1 : 2'd0, 0));
    vecs.push_back(mk("rr_drain", 0, 2'b00, 0, 1, 32'hA000_0008, 0, 2'b00, 0, A0, 1, 0));
    vecs.push_back(mk("lock0",    0, 2'b10, 0, 0, 32'h0,        0, 2'b00, 1, A1, 0, 0));
    vecs.push_back(mk("lock1",    0, 2'b11, 0, 0, 32'h0,        0, 2'b00, 1, A1, 0, 0));
    vecs.push_back(mk("lock2",    0, 2'b11, 0, 0, 32'h0,        0, 2'b00, 1, A1, 0, 0));
    vecs.push_back(mk("lock_gnt", 0, 2'b11, 1, 0, 32'h0,        0, 2'b10, 1, A1, 0, 0));
    vecs.push_back(mk("lock_nxt", 0, 2'b01, 1, 1, 32'hB000_0001, 0, 2'b01, 1, A0, 1, 0));
    vecs.push_back(mk("lock_rsp", 0, 2'b00, 0, 1, 32'hB000_0002, 1, 2'b00, 0, A0, 1, 0));
    vecs.push_back(mk("full_g1",  0, 2'b11, 1, 0, 32'h0,        0, 2'b10, 1, A1, 0, 0));
    vecs.push_back(mk("full_g2",  0, 2'b11, 1, 0, 32'h0,        0, 2'b01, 1, A0, 1, 0));
    vecs.push_back(mk("full_st",  0, 2'b11, 1, 0, 32'h0,        0, 2'b00, 0, A0, 2, 0));
    vecs.push_back(mk("full_pop", 0, 2'b11, 1, 1, 32'hC000_0001, 0, 2'b00, 0, A0, 2, 0));
    vecs.push_back(mk("full_rel", 0, 2'b11, 1, 0, 32'h0,        0, 2'b10, 1, A1, 1, 0));
    vecs.push_back(mk("mid_rst",  1, 2'b11, 1, 0, 32'h0,        0, 2'b00, 0, A0, 0, 0));
    vecs.push_back(mk("stale_rv", 0, 2'b00, 0, 1, 32'hD000_0001, 0, 2'b00, 0, A0, 0, 0));
    vecs.push_back(mk("post_gnt", 0, 2'b11, 1, 0, 32'h0,        0, 2'b01, 1, A0, 0, 1));
    vecs.push_back(mk("post_rsp", 0, 2'b00, 0, 1, 32'hD000_0002, 0, 2'b00, 0, A0, 1, 1));
    vecs.push_back(mk("unexp_rv", 0, 2'b00, 0, 1, 32'hD000_0003, 0, 2'b00, 0, A0, 0, 1));
    vecs.push_back(mk("unexp_st", 0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, A0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Locked host withdraws: no grant while it is gone, fresh arbitration next cycle
    step(mk("drop_lock", 0, 2'b10, 0, 0, 32'h0,        0, 2'b00, 1, A1, 0, 1));
    step(mk("drop_gone", 0, 2'b01, 1, 0, 32'h0,        0, 2'b00, 0, A0, 0, 1));
    step(mk("drop_arb",  0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, A0, 0, 1));
    step(mk("drop_rsp",  0, 2'b00, 0, 1, 32'hE000_0001, 0, 2'b00, 0, A0, 1, 1));
    step(mk("idle_end",  0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, A0, 0, 1));

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
